// File: rtl/vram_filler.sv
// vram_filler: paced VRAM window fill engine.
// Writes len words starting at base with a CONST / INCR / LFSR / CHECKER
// data pattern, one write every pace+2 cycles, one-shot or looping.
module vram_filler #(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 16,
    parameter int                PACE_W    = 17,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [1:0]        mode_i,
    input  logic              loop_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [PACE_W-1:0] pace_i,
    input  logic [DATA_W-1:0] pattern_i,
    output logic              vram_cea_o,
    output logic [ADDR_W-1:0] vram_ada_o,
    output logic [DATA_W-1:0] vram_din_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              wrap_o
);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

    localparam logic [1:0] M_CONST = 2'd0;
    localparam logic [1:0] M_INCR  = 2'd1;
    localparam logic [1:0] M_LFSR  = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [DATA_W-1:0] DATA_ONE = 1;
    localparam logic [ADDR_W:0]   REM_ONE  = 1;
    localparam logic [PACE_W-1:0] PACE_ONE = 1;

    state_t              state;
    logic [1:0]          mode_q;
    logic                loop_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     len_q;
    logic [PACE_W-1:0]   pace_q;
    logic [DATA_W-1:0]   first_q;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [ADDR_W:0]     rem;
    logic [PACE_W-1:0]   cnt;
    logic [DATA_W-1:0]   first_val;
    logic [DATA_W-1:0]   next_data;

    // First word of a pass; an all-zero LFSR seed would lock up, so use 1.
    always_comb begin
        first_val = pattern_i;
        if (mode_i == M_LFSR && pattern_i == '0)
            first_val = DATA_ONE;
    end

    // Data step between consecutive words of one pass.
    always_comb begin
        next_data = data;
        case (mode_q)
            M_CONST: next_data = data;
            M_INCR:  next_data = data + DATA_ONE;
            M_LFSR:  next_data = {data[DATA_W-2:0], ^(data & LFSR_TAPS)};
            default: next_data = ~data;
        endcase
    end

    assign vram_ada_o = addr;
    assign vram_din_o = data;

    // Control FSM; all strobes and pulses are registered and default low.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            mode_q     <= '0;
            loop_q     <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            pace_q     <= '0;
            first_q    <= '0;
            addr       <= '0;
            data       <= '0;
            rem        <= '0;
            cnt        <= '0;
            vram_cea_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            wrap_o     <= 1'b0;
        end else begin
            vram_cea_o <= 1'b0;
            done_o     <= 1'b0;
            wrap_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        mode_q  <= mode_i;
                        loop_q  <= loop_i;
                        base_q  <= base_i;
                        len_q   <= len_i;
                        pace_q  <= pace_i;
                        first_q <= first_val;
                        addr    <= base_i;
                        data    <= first_val;
                        rem     <= len_i;
                        cnt     <= pace_i;
                        busy_o  <= 1'b1;
                        if (len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (abort_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (cnt == '0) begin
                        state      <= WRITE;
                        vram_cea_o <= 1'b1;
                    end else begin
                        cnt <= cnt - PACE_ONE;
                    end
                end
                WRITE: begin
                    if (abort_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (rem == REM_ONE) begin
                        if (loop_q) begin
                            // Every pass restarts from identical state.
                            addr   <= base_q;
                            data   <= first_q;
                            rem    <= len_q;
                            cnt    <= pace_q;
                            wrap_o <= 1'b1;
                            state  <= WAIT;
                        end else begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end
                    end else begin
                        addr  <= addr + ADDR_ONE;
                        data  <= next_data;
                        rem   <= rem - REM_ONE;
                        cnt   <= pace_q;
                        state <= WAIT;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_filler.sv
// tb_vram_filler: directed and randomized fills checked cycle by cycle
// against a closed-form schedule model of the fill engine.
module tb_vram_filler;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int PW = 17;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = '0;
    logic          loop = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic [PW-1:0] pace = '0;
    logic [DW-1:0] pat = '0;
    logic          cea, busy, done, wrap;
    logic [AW-1:0] ada;
    logic [DW-1:0] din;

    int nvec = 0;
    int errs = 0;

    vram_filler dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
        .mode_i(mode), .loop_i(loop), .base_i(base), .len_i(len),
        .pace_i(pace), .pattern_i(pat),
        .vram_cea_o(cea), .vram_ada_o(ada), .vram_din_o(din),
        .busy_o(busy), .done_o(done), .wrap_o(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Word j of a pass, straight from the pattern definitions.
    function automatic logic [DW-1:0] word_at(input logic [1:0] m, input logic [DW-1:0] pt, input int j);
        logic [DW-1:0] l;
        case (m)
            2'd0: return pt;
            2'd1: return DW'(int'(pt) + j);
            2'd2: begin
                l = (pt == '0) ? 16'h0001 : pt;
                for (int i = 0; i < j; i++) l = {l[DW-2:0], ^(l & 16'hB400)};
                return l;
            end
            default: return (j % 2 == 1) ? ~pt : pt;
        endcase
    endfunction

    // One operation: start with the given parameters, optionally abort at
    // cycle ab (sampled at that edge), scramble inputs and pulse start while busy.
    task automatic run(input logic [1:0] m, input logic lp, input logic [AW-1:0] b,
                       input int l, input int p, input logic [DW-1:0] pt, input int ab);
        int T, last, k, j;
        logic e_cea, e_busy, e_done, e_wrap, live;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        T = p + 2;
        last = (l == 0) ? 1 : (lp ? ab : l * T + 1);
        mode = m; loop = lp; base = b; len = (AW+1)'(l); pace = PW'(p); pat = pt;
        abort = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= last + 2; c++) begin
            e_cea = 0; e_busy = 0; e_done = 0; e_wrap = 0; e_addr = '0; e_data = '0;
            live = (ab == 0) || (c <= ab);
            if (live) begin
                if (l == 0) begin
                    e_busy = (c == 1);
                    e_done = (c == 1);
                end else begin
                    k = c / T - 1;
                    e_cea = (c % T == 0) && (k >= 0) && (lp || k < l);
                    if (lp) begin
                        e_busy = 1;
                        e_wrap = (c > 1) && ((c - 1) % T == 0) && (((c - 1) / T) % l == 0);
                        j = (k >= 0) ? k % l : 0;
                    end else begin
                        e_busy = (c <= l * T + 1);
                        e_done = (c == l * T + 1);
                        j = k;
                    end
                    e_addr = AW'(int'(b) + j);
                    e_data = word_at(m, pt, j);
                end
            end
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("wrap", 32'(wrap), 32'(e_wrap));
            chk("cea", 32'(cea), 32'(e_cea));
            if (e_cea) begin
                chk("addr", 32'(ada), 32'(e_addr));
                chk("data", 32'(din), 32'(e_data));
            end
            abort = (c == ab);
            start = e_busy && ($urandom_range(0, 2) == 0);
            mode = 2'($urandom); loop = 1'($urandom); base = AW'($urandom);
            len = (AW+1)'($urandom); pace = PW'($urandom_range(0, 7)); pat = DW'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        int l, p, ab;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cea", 32'(cea), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_ada", 32'(ada), 0);
        chk("rst_din", 32'(din), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        run(2'd0, 1'b0, 10'd5, 3, 0, 16'hABCD, 0);
        run(2'd2, 1'b0, 10'd0, 4, 2, 16'h0000, 0);
        run(2'd2, 1'b0, 10'd7, 2, 1, 16'hA000, 0);
        run(2'd1, 1'b0, 10'h3FE, 4, 0, 16'hFFFF, 0);
        run(2'd3, 1'b1, 10'd20, 2, 1, 16'h00FF, 11);
        run(2'd0, 1'b0, 10'd9, 0, 3, 16'h1234, 0);
        run(2'd1, 1'b1, 10'd9, 0, 3, 16'h1234, 0);
        run(2'd1, 1'b0, 10'h3F0, 1030, 0, 16'hFFF0, 0);
        run(2'd2, 1'b1, 10'd1, 1, 0, 16'h0000, 9);

        // Asynchronous reset in the middle of a paced WAIT.
        mode = 2'd1; loop = 1'b0; base = 10'h155; len = 11'd3; pace = 17'd5; pat = 16'h5A5A;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cea", 32'(cea), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_wrap", 32'(wrap), 0);
        chk("arst_ada", 32'(ada), 0);
        chk("arst_din", 32'(din), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        run(2'd0, 1'b0, 10'd5, 3, 0, 16'hABCD, 0);

        repeat (25) begin
            l = $urandom_range(0, 20);
            p = $urandom_range(0, 5);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, l * (p + 2) + 1) : 0;
            run(2'($urandom), 1'b0, AW'($urandom), l, p, DW'($urandom), ab);
        end
        repeat (8) begin
            l = $urandom_range(1, 6);
            p = $urandom_range(0, 4);
            run(2'($urandom), 1'b1, AW'($urandom), l, p, DW'($urandom), $urandom_range(5, 60));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
